// File: rtl/pio_exec_pacer.sv
// Paces one PIO state machine: one exec strobe per divider tick in READY, then burns the delay field in ticks.
// exec is combinational (zero latency from tick); retire/busy/stall_count are registered; stalls retry on the next tick.
module pio_exec_pacer #(
    parameter int DELAY_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               enable,
    input  logic               restart,
    input  logic               instr_valid,
    input  logic [DELAY_W-1:0] instr_delay,
    input  logic               stall,
    output logic               exec,
    output logic               retire,
    output logic               busy,
    output logic [CNT_W-1:0]   stall_count
);

    logic [DELAY_W-1:0] delay_cnt;
    logic               ready;
    logic               live_tick;

    assign ready     = (delay_cnt == '0);
    assign busy      = !ready;
    assign live_tick = tick & enable & !restart;
    // A tick spent on the delay countdown (including 1->0) can never also execute.
    assign exec      = live_tick & ready & instr_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            delay_cnt   <= '0;
            retire      <= 1'b0;
            stall_count <= '0;
        end else if (restart) begin
            delay_cnt   <= '0;
            retire      <= 1'b0;
            stall_count <= '0;
        end else begin
            retire <= exec & !stall;
            if (exec) begin
                if (!stall) begin
                    delay_cnt <= instr_delay;
                end else if (stall_count != '1) begin
                    stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (live_tick && !ready) begin
                delay_cnt <= delay_cnt - {{(DELAY_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_pio_exec_pacer.sv
// Directed bench for pio_exec_pacer: exec pacing, delay burn, stalls, enable freeze, restart and async reset.
module tb_pio_exec_pacer;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic        enable;
    logic        restart;
    logic        instr_valid;
    logic [4:0]  instr_delay;
    logic        stall;
    logic        exec;
    logic        retire;
    logic        busy;
    logic [15:0] stall_count;

    int checks   = 0;
    int failures = 0;
    logic ex;

    always #5 clock = ~clock;

    pio_exec_pacer #(.DELAY_W(5), .CNT_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .enable      (enable),
        .restart     (restart),
        .instr_valid (instr_valid),
        .instr_delay (instr_delay),
        .stall       (stall),
        .exec        (exec),
        .retire      (retire),
        .busy        (busy),
        .stall_count (stall_count)
    );

    // Entered 1 time unit after a rising edge; returns exec as seen mid-cycle, leaves 1 unit after the next edge.
    task automatic step(input logic t, output logic e);
        tick = t;
        #1;
        e = exec;
        @(posedge clock);
        #1;
        tick = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; tick = 1'b0; enable = 1'b1; restart = 1'b0;
        instr_valid = 1'b0; instr_delay = '0; stall = 1'b0;
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (retire !== 1'b0) begin failures++; $display("FAIL reset_retire got=%b exp=0", retire); end
        checks++; if (stall_count !== 16'h0) begin failures++; $display("FAIL reset_stall_count got=%h exp=0000", stall_count); end
        checks++; if (exec !== 1'b0) begin failures++; $display("FAIL reset_exec got=%b exp=0", exec); end
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_basic;
        instr_valid = 1'b1; instr_delay = 5'd0; stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, ex);
            checks++; if (ex !== 1'b1) begin failures++; $display("FAIL basic_exec tick=%0d got=%b exp=1", k, ex); end
            checks++; if (retire !== 1'b1) begin failures++; $display("FAIL basic_retire tick=%0d got=%b exp=1", k, retire); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy tick=%0d got=%b exp=0", k, busy); end
            step(1'b0, ex);
            checks++; if (ex !== 1'b0) begin failures++; $display("FAIL basic_noexec tick=%0d got=%b exp=0", k, ex); end
            checks++; if (retire !== 1'b0) begin failures++; $display("FAIL basic_retire_pulse tick=%0d got=%b exp=0", k, retire); end
            step(1'b0, ex);
            step(1'b0, ex);
        end
        instr_valid = 1'b0;
        step(1'b1, ex);
        checks++; if (ex !== 1'b0) begin failures++; $display("FAIL lost_tick_exec got=%b exp=0", ex); end
        checks++; if (retire !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL lost_tick_state retire=%b busy=%b exp=0/0", retire, busy); end
        step(1'b0, ex);
    endtask

    task automatic test_delay;
        instr_valid = 1'b1; instr_delay = 5'd3; stall = 1'b0;
        step(1'b1, ex);
        checks++; if (ex !== 1'b1) begin failures++; $display("FAIL delay_exec0 got=%b exp=1", ex); end
        checks++; if (busy !== 1'b1 || retire !== 1'b1) begin failures++; $display("FAIL delay_start busy=%b retire=%b exp=1/1", busy, retire); end
        instr_delay = 5'd31;
        step(1'b0, ex);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, ex);
            checks++; if (ex !== 1'b0) begin failures++; $display("FAIL delay_noexec tick=%0d got=%b exp=0", i, ex); end
            checks++; if (busy !== (i < 3)) begin failures++; $display("FAIL delay_busy tick=%0d got=%b exp=%b", i, busy, (i < 3)); end
            step(1'b0, ex);
        end
        instr_delay = 5'd0;
        step(1'b1, ex);
        checks++; if (ex !== 1'b1) begin failures++; $display("FAIL delay_exec4 got=%b exp=1", ex); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL delay_after_busy got=%b exp=0", busy); end
        step(1'b0, ex);
    endtask

    task automatic test_stall;
        instr_valid = 1'b1; instr_delay = 5'd0; stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, ex);
            checks++; if (ex !== 1'b1) begin failures++; $display("FAIL stall_exec tick=%0d got=%b exp=1", k, ex); end
            checks++; if (retire !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stall_noretire tick=%0d retire=%b busy=%b exp=0/0", k, retire, busy); end
            step(1'b0, ex);
        end
        stall = 1'b0;
        step(1'b1, ex);
        checks++; if (ex !== 1'b1) begin failures++; $display("FAIL stall_exec2 got=%b exp=1", ex); end
        checks++; if (retire !== 1'b1) begin failures++; $display("FAIL stall_retire2 got=%b exp=1", retire); end
        checks++; if (stall_count !== 16'd2) begin failures++; $display("FAIL stall_count2 got=%0d exp=2", stall_count); end
        stall = 1'b1;
        step(1'b0, ex);
        checks++; if (stall_count !== 16'd2) begin failures++; $display("FAIL stall_ignored got=%0d exp=2", stall_count); end
        tick = 1'b1;
        repeat (65536 + 5) @(posedge clock);
        #1;
        tick = 1'b0;
        checks++; if (stall_count !== 16'hFFFF) begin failures++; $display("FAIL stall_saturate got=%h exp=ffff", stall_count); end
        stall = 1'b0; restart = 1'b1;
        step(1'b0, ex);
        restart = 1'b0;
        checks++; if (stall_count !== 16'h0) begin failures++; $display("FAIL stall_restart_clear got=%h exp=0000", stall_count); end
    endtask

    task automatic test_enable;
        instr_valid = 1'b1; instr_delay = 5'd7; stall = 1'b0;
        step(1'b1, ex);
        checks++; if (ex !== 1'b1) begin failures++; $display("FAIL en_exec0 got=%b exp=1", ex); end
        instr_delay = 5'd0;
        step(1'b0, ex);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, ex);
            checks++; if (ex !== 1'b0) begin failures++; $display("FAIL en_predelay tick=%0d got=%b exp=0", i, ex); end
            step(1'b0, ex);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, ex);
            checks++; if (ex !== 1'b0) begin failures++; $display("FAIL en_frozen tick=%0d got=%b exp=0", i, ex); end
            step(1'b0, ex);
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_frozen_busy got=%b exp=1", busy); end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, ex);
            checks++; if (ex !== 1'b0) begin failures++; $display("FAIL en_resume tick=%0d got=%b exp=0", i, ex); end
            step(1'b0, ex);
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_done_busy got=%b exp=0", busy); end
        step(1'b1, ex);
        checks++; if (ex !== 1'b1) begin failures++; $display("FAIL en_exec6 got=%b exp=1", ex); end
        step(1'b0, ex);
    endtask

    task automatic test_restart;
        instr_valid = 1'b1; instr_delay = 5'd0; stall = 1'b1;
        step(1'b1, ex);
        stall = 1'b0;
        checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL rs_pre_count got=%0d exp=1", stall_count); end
        step(1'b0, ex);
        instr_delay = 5'd10;
        step(1'b1, ex);
        checks++; if (ex !== 1'b1) begin failures++; $display("FAIL rs_exec0 got=%b exp=1", ex); end
        instr_delay = 5'd0;
        step(1'b0, ex);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ex);
            step(1'b0, ex);
        end
        restart = 1'b1;
        step(1'b1, ex);
        restart = 1'b0;
        checks++; if (ex !== 1'b0) begin failures++; $display("FAIL rs_exec_gated got=%b exp=0", ex); end
        checks++; if (busy !== 1'b0 || stall_count !== 16'h0) begin failures++; $display("FAIL rs_clear busy=%b count=%0d exp=0/0", busy, stall_count); end
        step(1'b1, ex);
        checks++; if (ex !== 1'b1 || retire !== 1'b1) begin failures++; $display("FAIL rs_next_exec exec=%b retire=%b exp=1/1", ex, retire); end
        restart = 1'b1;
        step(1'b1, ex);
        restart = 1'b0;
        checks++; if (ex !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL rs_ready_gate exec=%b retire=%b exp=0/0", ex, retire); end
        step(1'b0, ex);
    endtask

    task automatic test_reset_mid;
        instr_valid = 1'b1; instr_delay = 5'd0; stall = 1'b1;
        step(1'b1, ex);
        stall = 1'b0;
        step(1'b0, ex);
        instr_delay = 5'd10;
        step(1'b1, ex);
        instr_delay = 5'd0;
        checks++; if (busy !== 1'b1 || retire !== 1'b1 || stall_count !== 16'd1) begin
            failures++; $display("FAIL rm_pre busy=%b retire=%b count=%0d exp=1/1/1", busy, retire, stall_count);
        end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || retire !== 1'b0 || stall_count !== 16'h0) begin
            failures++; $display("FAIL rm_async busy=%b retire=%b count=%0d exp=0/0/0", busy, retire, stall_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(1'b1, ex);
        checks++; if (ex !== 1'b1 || retire !== 1'b1) begin failures++; $display("FAIL rm_first_exec exec=%b retire=%b exp=1/1", ex, retire); end
        step(1'b0, ex);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_delay;
        test_stall;
        test_enable;
        test_restart;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
